// File: rtl/pattern_recognizer_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, Mealy match and saturating count.
// Optional PATREC_MASK_EN adds a per-bit compare mask loaded alongside the pattern.
module pattern_recognizer_param #(
   parameter int unsigned        PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1101,
   parameter bit                 OVERLAP = 1'b1,
   parameter int unsigned        CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               string_in,
   input  logic               in_valid,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
`ifdef PATREC_MASK_EN
   input  logic [PAT_LEN-1:0] pat_mask_in,
`endif
   output logic               seen,
   output logic               seen_q,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam int unsigned HIST_W = PAT_LEN - 1;
   localparam int unsigned FILL_W = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [FILL_W-1:0]   fill, fill_nxt;
   logic [HIST_W-1:0]   hist, hist_nxt;
   logic [PAT_LEN-1:0]  pattern, pattern_nxt;
   logic [PAT_LEN-1:0]  window;
   logic                match;

   assign window = {hist, string_in};

`ifdef PATREC_MASK_EN
   logic [PAT_LEN-1:0] mask, mask_nxt;

   // Masked-off positions never contribute a mismatch
   assign match = (((window ^ pattern) & mask) == '0);
`else
   assign match = (window == pattern);
`endif

   assign armed = (state == ARMED);
   assign seen  = in_valid & armed & ~pat_load & match;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FILL;
         fill      <= '0;
         hist      <= '0;
         pattern   <= PAT_RST;
`ifdef PATREC_MASK_EN
         mask      <= '1;
`endif
         seen_q    <= 1'b0;
         match_cnt <= '0;
      end else begin
         state     <= state_nxt;
         fill      <= fill_nxt;
         hist      <= hist_nxt;
         pattern   <= pattern_nxt;
`ifdef PATREC_MASK_EN
         mask      <= mask_nxt;
`endif
         seen_q    <= seen;
         if (seen && (match_cnt != '1))
            match_cnt <= match_cnt + CNT_W'(1);
      end
   end

   // History/fill update; a pattern load takes priority over any incoming bit
   always_comb begin
      fill_nxt    = fill;
      hist_nxt    = hist;
      pattern_nxt = pattern;
`ifdef PATREC_MASK_EN
      mask_nxt    = mask;
`endif
      if (pat_load) begin
         pattern_nxt = pat_in;
`ifdef PATREC_MASK_EN
         mask_nxt    = pat_mask_in;
`endif
         hist_nxt    = '0;
         fill_nxt    = '0;
      end else if (in_valid) begin
         if (seen && !OVERLAP) begin
            hist_nxt = '0;
            fill_nxt = '0;
         end else begin
            hist_nxt = HIST_W'(window);
            fill_nxt = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
         end
      end
      state_nxt = (fill_nxt == FILL_MAX) ? ARMED : FILL;
   end

endmodule

// File: doc/pattern_recognizer_param.md
Name: pattern_recognizer_param

Overview:
Parametrised serial bit-pattern detector with Mealy match output and configurable pattern length.
- Pattern is runtime-loadable; overlapping or non-overlapping detection is selectable.
- Adds an input-valid qualifier, a registered match copy and a saturating match counter.
- Sits on a serial data path behind a bit-stream source and flags each completed occurrence of the pattern.

Parameters:
- PAT_LEN, 4, pattern length in bits (>= 2).
- PAT_RST, 4'b1101, pattern held after reset (PAT_LEN bits, MSB = first bit received).
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = history cleared after each match.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- string_in  in  1  serial data bit
- in_valid  in  1  string_in is sampled only when 1
- pat_load  in  1  load pat_in as new pattern this cycle
- pat_in  in  PAT_LEN  new pattern, MSB first
- seen  out  1  Mealy match, combinational, same cycle as final bit
- seen_q  out  1  seen registered (1 cycle later)
- match_cnt  out  CNT_W  saturating count of matches
- armed  out  1  history holds >= PAT_LEN-1 valid bits

Behaviour:
Reset (reset_n low, async):
- pattern = PAT_RST; history = 0; fill = 0; seen_q = 0; match_cnt = 0; armed = 0.
- seen = 0 while in reset.

State:
- hist[PAT_LEN-2:0] shift register; fill counter 0..PAT_LEN-1.
- FSM derived from fill: FILL (fill < PAT_LEN-1), ARMED (fill == PAT_LEN-1). armed = (state == ARMED).

Matching:
- seen = in_valid & armed & ~pat_load & ({hist, string_in} == pattern). Purely combinational from state and inputs.
- On a clock edge with in_valid=1 and pat_load=0:
  - hist <= {hist[PAT_LEN-3:0], string_in}.
  - fill increments, saturating at PAT_LEN-1.
- If seen=1 and OVERLAP=0: hist <= 0 and fill <= 0 instead of the shift/increment above.
- If seen=1 and OVERLAP=1: the normal shift applies and fill stays at PAT_LEN-1.
- in_valid=0: hist, fill and pattern hold; seen = 0.

Pattern load:
- pat_load=1: pattern <= pat_in; hist <= 0; fill <= 0; seen forced 0.
- If in_valid is also 1 in that cycle, pat_load wins and the bit is discarded.

Outputs:
- seen_q <= seen every cycle.
- match_cnt increments on each cycle with seen=1 and holds at 2^CNT_W-1. It is not cleared by pat_load, only by reset.
- Latency: seen in the same cycle as the final pattern bit; seen_q and the match_cnt update one cycle later.
- Reset asserted mid-stream discards partial history; the first match after reset needs PAT_LEN fresh valid bits.

Optional Feature:
PATREC_MASK_EN
- Defined: adds input port pat_mask_in [PAT_LEN-1:0] and a mask register.
  - Mask is loaded together with pat_in on pat_load; reset value is all ones.
  - Compare uses only bit positions where mask=1; mask=0 positions are don't-care.
  - An all-zero mask matches every valid bit once armed.
- Undefined: no port, no register; full exact compare.

Test Plan:
- Default params, in_valid=1, stream 1,1,0,1 → seen=1 on the 4th bit cycle only; seen_q=1 the next cycle; match_cnt=1.
- OVERLAP=1, stream 1,1,0,1,1,0,1 → seen on bits 4 and 7, match_cnt=2. OVERLAP=0, same stream → seen on bit 4 only, match_cnt=1.
- Stream 1,1,0,1 with in_valid=0 for 3 cycles between each bit → seen=1 only on the cycle the 4th valid bit arrives; no seen during gaps.
- After 1,1,0 apply pat_load with pat_in=4'b0000 and in_valid=1, string_in=1 → armed=0, seen=0. Then 0,0,0 → no match; 4th 0 → seen=1, and every further 0 gives seen=1.
- CNT_W=2, feed 5 non-adjacent 1101 patterns → match_cnt reads 1,2,3,3,3.
- After 1,1,0 pulse reset_n low asynchronously (mid-cycle), release, then feed 1 → seen=0, match_cnt=0, armed=0; a subsequent 1,1,0,1 → seen=1.
